branch_prediction_unit: RTL and testbench

//  Fetch-stage branch predictor feeding pipeline control: direct-mapped BTB, one 2-bit

---
 rtl/branch_prediction_unit.sv | 103 ++++++++++
 tb/tb_branch_prediction_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/branch_prediction_unit.sv
// Fetch-stage branch predictor: direct-mapped BTB with one 2-bit saturating
// counter per entry. Lookup is purely combinational on pc_i; updates from EXE
// land on the clock edge and are visible on the following cycle (no bypass).
module branch_prediction_unit #(
  parameter int XLEN      = 32,
  parameter int ENTRY_NUM = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            branch_hit_o,
  output logic            branch_is_cond_o,
  output logic            branch_decision_o,
  output logic [XLEN-1:0] branch_target_addr_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_is_cond_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i
);

  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  logic [ENTRY_NUM-1:0]            valid_q, valid_d;
  logic [ENTRY_NUM-1:0]            cond_q,  cond_d;
  logic [ENTRY_NUM-1:0][TAG_W-1:0] tag_q,   tag_d;
  logic [ENTRY_NUM-1:0][XLEN-1:0]  tgt_q,   tgt_d;
  logic [ENTRY_NUM-1:0][1:0]       cnt_q,   cnt_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;

  assign lk_idx = pc_i[IDX_W+1:2];
  assign lk_tag = pc_i[XLEN-1:IDX_W+2];
  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[XLEN-1:IDX_W+2];

  // Lookup reads registered contents only; outputs are forced low during reset
  // so stale entries cannot leak out before the clearing edge.
  always_comb begin
    lk_hit               = !rst_i && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    branch_hit_o         = lk_hit;
    branch_is_cond_o     = lk_hit && cond_q[lk_idx];
    branch_decision_o    = lk_hit && (cond_q[lk_idx] ? cnt_q[lk_idx][1] : 1'b1);
    branch_target_addr_o = lk_hit ? tgt_q[lk_idx] : '0;
  end

  // Next-state for the table: at most one entry changes per cycle. A stalled
  // update is simply not applied, so holding it applies it once on release.
  always_comb begin
    valid_d = valid_q;
    cond_d  = cond_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    if (upd_valid_i && !stall_i) begin
      if (up_hit) begin
        tgt_d[up_idx]  = upd_target_i;
        cond_d[up_idx] = upd_is_cond_i;
        if (!upd_is_cond_i)
          cnt_d[up_idx] = CNT_ST;
        else if (upd_taken_i && cnt_q[up_idx] != CNT_ST)
          cnt_d[up_idx] = cnt_q[up_idx] + 2'd1;
        else if (!upd_taken_i && cnt_q[up_idx] != CNT_SNT)
          cnt_d[up_idx] = cnt_q[up_idx] - 2'd1;
      end else if (upd_taken_i) begin
        // Allocation evicts whatever shares the index.
        valid_d[up_idx] = 1'b1;
        tag_d[up_idx]   = up_tag;
        tgt_d[up_idx]   = upd_target_i;
        cond_d[up_idx]  = upd_is_cond_i;
        cnt_d[up_idx]   = upd_is_cond_i ? CNT_WT : CNT_ST;
      end
    end
  end

  // Table state; reset clears everything and overrides a concurrent update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      cond_q  <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= {ENTRY_NUM{CNT_WNT}};
    end else begin
      valid_q <= valid_d;
      cond_q  <= cond_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_prediction_unit.sv
// Directed bench for branch_prediction_unit: allocation, counter saturation,
// aliasing, JAL entries, stall handling, same-cycle update and reset.
module tb_branch_prediction_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic [31:0] pc_i;
  logic        branch_hit_o;
  logic        branch_is_cond_o;
  logic        branch_decision_o;
  logic [31:0] branch_target_addr_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_is_cond_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;

  int tests = 0;
  int fails = 0;

  branch_prediction_unit #(.XLEN(32), .ENTRY_NUM(64)) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .stall_i              (stall_i),
    .pc_i                 (pc_i),
    .branch_hit_o         (branch_hit_o),
    .branch_is_cond_o     (branch_is_cond_o),
    .branch_decision_o    (branch_decision_o),
    .branch_target_addr_o (branch_target_addr_o),
    .upd_valid_i          (upd_valid_i),
    .upd_pc_i             (upd_pc_i),
    .upd_is_cond_i        (upd_is_cond_i),
    .upd_taken_i          (upd_taken_i),
    .upd_target_i         (upd_target_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Drive pc_i, settle, compare all four lookup outputs.
  task automatic look(input string name, input logic [31:0] pc, input logic hit,
                      input logic cnd, input logic dec, input logic [31:0] tgt);
    pc_i = pc;
    #1;
    check({name, ".hit"},  {31'd0, branch_hit_o},      {31'd0, hit});
    check({name, ".cond"}, {31'd0, branch_is_cond_o},  {31'd0, cnd});
    check({name, ".dec"},  {31'd0, branch_decision_o}, {31'd0, dec});
    check({name, ".tgt"},  branch_target_addr_o,       tgt);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One-cycle update pulse.
  task automatic upd(input logic [31:0] pc, input logic cnd, input logic tk, input logic [31:0] tgt);
    upd_pc_i = pc; upd_is_cond_i = cnd; upd_taken_i = tk; upd_target_i = tgt;
    upd_valid_i = 1'b1;
    tick();
    upd_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; pc_i = 32'h1000;
    upd_valid_i = 1'b0; upd_pc_i = '0; upd_is_cond_i = 1'b0;
    upd_taken_i = 1'b0; upd_target_i = '0;
    tick(); tick();
    look("rst_hold", 32'h1000, 0, 0, 0, 32'h0);
    rst_i = 1'b0;

    // 1: empty table
    look("empty", 32'h1000, 0, 0, 0, 32'h0);

    // 2: allocate cond taken -> WT
    upd(32'h1000, 1, 1, 32'h1040);
    look("alloc", 32'h1000, 1, 1, 1, 32'h1040);
    look("alloc_lowbits", 32'h1003, 1, 1, 1, 32'h1040);

    // 3: counter walk: 10 -> 01 -> 00 -> 00, then 01, 10, 11, then NT -> 10
    upd(32'h1000, 1, 0, 32'h1040); look("nt1", 32'h1000, 1, 1, 0, 32'h1040);
    upd(32'h1000, 1, 0, 32'h1040); look("nt2", 32'h1000, 1, 1, 0, 32'h1040);
    upd(32'h1000, 1, 0, 32'h1040); look("nt3", 32'h1000, 1, 1, 0, 32'h1040);
    upd(32'h1000, 1, 1, 32'h1040); look("t1",  32'h1000, 1, 1, 0, 32'h1040);
    upd(32'h1000, 1, 1, 32'h1040); look("t2",  32'h1000, 1, 1, 1, 32'h1040);
    upd(32'h1000, 1, 1, 32'h1040); look("t3",  32'h1000, 1, 1, 1, 32'h1040);
    upd(32'h1000, 1, 0, 32'h1040); look("sat_hi", 32'h1000, 1, 1, 1, 32'h1040);

    // 4: aliasing on index 0, not-taken misses never allocate
    upd(32'h1100, 1, 1, 32'h1200);
    look("evicted", 32'h1000, 0, 0, 0, 32'h0);
    look("alias",   32'h1100, 1, 1, 1, 32'h1200);
    upd(32'h2000, 1, 0, 32'h2222);
    look("nt_miss", 32'h2000, 0, 0, 0, 32'h0);
    upd(32'h1000, 1, 0, 32'h1040);
    look("nt_miss_keep", 32'h1100, 1, 1, 1, 32'h1200);

    // 5: JAL entry, then a stalled update on 0x1100 (cnt 10)
    upd(32'h2004, 0, 1, 32'h3000);
    look("jal", 32'h2004, 1, 0, 1, 32'h3000);
    upd_pc_i = 32'h1100; upd_is_cond_i = 1'b1; upd_taken_i = 1'b0;
    upd_target_i = 32'h1200; upd_valid_i = 1'b1; stall_i = 1'b1;
    tick(); look("stall1", 32'h1100, 1, 1, 1, 32'h1200);
    tick(); look("stall2", 32'h1100, 1, 1, 1, 32'h1200);
    tick(); look("stall3", 32'h1100, 1, 1, 1, 32'h1200);
    stall_i = 1'b0;
    tick(); upd_valid_i = 1'b0;
    look("unstall", 32'h1100, 1, 1, 0, 32'h1200);
    upd(32'h1100, 1, 1, 32'h1200);
    look("once", 32'h1100, 1, 1, 1, 32'h1200);

    // 6: same-cycle update and lookup: old contents now, new next cycle
    upd_pc_i = 32'h1100; upd_is_cond_i = 1'b1; upd_taken_i = 1'b0;
    upd_target_i = 32'h1300; upd_valid_i = 1'b1;
    look("same_old", 32'h1100, 1, 1, 1, 32'h1200);
    tick(); upd_valid_i = 1'b0;
    look("same_new", 32'h1100, 1, 1, 0, 32'h1300);

    // reset with concurrent update: outputs gated, update dropped
    rst_i = 1'b1;
    upd_pc_i = 32'h3000; upd_is_cond_i = 1'b1; upd_taken_i = 1'b1;
    upd_target_i = 32'h3100; upd_valid_i = 1'b1;
    look("rst_gate", 32'h2004, 0, 0, 0, 32'h0);
    tick();
    rst_i = 1'b0; upd_valid_i = 1'b0;
    look("rst_drop", 32'h3000, 0, 0, 0, 32'h0);
    look("rst_jal",  32'h2004, 0, 0, 0, 32'h0);
    look("rst_cond", 32'h1100, 0, 0, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
